// File: rtl/reg_file_ctx_if.sv
// Bus bundle for reg_file_ctx: write port, two read ports and bank save/restore control.
interface reg_file_ctx_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] IN;
  logic [ADDR_WIDTH-1:0] INADDRESS;
  logic                  WRITE;
  logic [ADDR_WIDTH-1:0] OUT1ADDRESS;
  logic [ADDR_WIDTH-1:0] OUT2ADDRESS;
  logic [DATA_WIDTH-1:0] OUT1;
  logic [DATA_WIDTH-1:0] OUT2;
  logic                  SAVE;
  logic                  RESTORE;
  logic                  BUSY;
  logic                  WRITE_DROP;

  modport master (
    output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, SAVE, RESTORE,
    input  OUT1, OUT2, BUSY, WRITE_DROP
  );

  modport slave (
    input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, SAVE, RESTORE,
    output OUT1, OUT2, BUSY, WRITE_DROP
  );
endinterface

// File: rtl/reg_file_ctx.sv
// Two-read/one-write register file with a shadow bank; SAVE/RESTORE copy one
// register per cycle while BUSY, and writes arriving during a copy are dropped.
module reg_file_ctx #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int ZERO_REG   = 0
) (
  input logic           CLK,
  input logic           RESET,
  reg_file_ctx_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, SAVING, RESTORING} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] main_q   [DEPTH];
  logic [DATA_WIDTH-1:0] shadow_q [DEPTH];
  logic [DATA_WIDTH-1:0] out1_q, out1_d, out2_q, out2_d;
  logic                  busy_q, busy_d, drop_q, drop_d;
  logic                  wr_acc, wr_en, wr_zero;

  assign wr_acc  = bus.WRITE && !busy_q;
  assign wr_zero = (ZERO_REG != 0) && (bus.INADDRESS == '0);
  assign wr_en   = wr_acc && !wr_zero;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.SAVE)         state_d = SAVING;
        else if (bus.RESTORE) state_d = RESTORING;
      end
      SAVING, RESTORING: begin
        if (cnt_q == '1) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
    drop_d = bus.WRITE && busy_q;
  end

  // Write-first bypass; address 0 is forced to zero when ZERO_REG is set.
  always_comb begin
    out1_d = main_q[bus.OUT1ADDRESS];
    out2_d = main_q[bus.OUT2ADDRESS];
    if (wr_en && (bus.INADDRESS == bus.OUT1ADDRESS)) out1_d = bus.IN;
    if (wr_en && (bus.INADDRESS == bus.OUT2ADDRESS)) out2_d = bus.IN;
    if ((ZERO_REG != 0) && (bus.OUT1ADDRESS == '0)) out1_d = '0;
    if ((ZERO_REG != 0) && (bus.OUT2ADDRESS == '0)) out2_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      out1_q  <= '0;
      out2_q  <= '0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out1_q  <= out1_d;
      out2_q  <= out2_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        main_q[i]   <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      if (wr_en)                  main_q[bus.INADDRESS] <= bus.IN;
      if (state_q == RESTORING)   main_q[cnt_q]         <= shadow_q[cnt_q];
      if (state_q == SAVING)      shadow_q[cnt_q]       <= main_q[cnt_q];
    end
  end

  assign bus.OUT1       = out1_q;
  assign bus.OUT2       = out2_q;
  assign bus.BUSY       = busy_q;
  assign bus.WRITE_DROP = drop_q;
endmodule

// File: tb/tb_reg_file_ctx.sv
// Directed bench for reg_file_ctx: default instance plus a ZERO_REG=1 instance.
module tb_reg_file_ctx;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   nbusy;

  always #5 clk = ~clk;

  reg_file_ctx_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) abus ();
  reg_file_ctx_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) zbus ();

  reg_file_ctx #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(0)) u_dut (
    .CLK(clk), .RESET(rst), .bus(abus)
  );
  reg_file_ctx #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG(1)) u_dutz (
    .CLK(clk), .RESET(rst), .bus(zbus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    abus.WRITE = 1'b1; abus.INADDRESS = a; abus.IN = d;
    tick();
    abus.WRITE = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    abus.IN = '0; abus.INADDRESS = '0; abus.WRITE = 1'b0;
    abus.OUT1ADDRESS = '0; abus.OUT2ADDRESS = '0; abus.SAVE = 1'b0; abus.RESTORE = 1'b0;
    zbus.IN = '0; zbus.INADDRESS = '0; zbus.WRITE = 1'b0;
    zbus.OUT1ADDRESS = '0; zbus.OUT2ADDRESS = '0; zbus.SAVE = 1'b0; zbus.RESTORE = 1'b0;
    tick(); tick();
    chk("rst_out1", abus.OUT1, 8'h00);
    chk("rst_out2", abus.OUT2, 8'h00);
    chk("rst_busy", {7'd0, abus.BUSY}, 8'h00);
    chk("rst_drop", {7'd0, abus.WRITE_DROP}, 8'h00);
    rst = 1'b0;

    // basic writes and two-port read
    wr(3'd0, 8'h11);
    wr(3'd1, 8'h88);
    abus.OUT1ADDRESS = 3'd0; abus.OUT2ADDRESS = 3'd1;
    tick();
    chk("read_r0", abus.OUT1, 8'h11);
    chk("read_r1", abus.OUT2, 8'h88);

    // write-first bypass
    abus.OUT1ADDRESS = 3'd3;
    wr(3'd3, 8'h5A);
    chk("bypass_out1", abus.OUT1, 8'h5A);
    chk("bypass_out2", abus.OUT2, 8'h88);

    // load, save, busy length
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h10 + 8'(i));
    abus.SAVE = 1'b1;
    tick();
    abus.SAVE = 1'b0;
    chk("save_busy", {7'd0, abus.BUSY}, 8'h01);
    nbusy = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (abus.BUSY) nbusy++;
      else break;
    end
    chk("save_busy_len", 8'(nbusy), 8'd8);

    // overwrite, then restore
    for (int i = 0; i < 8; i++) wr(3'(i), 8'hFF);
    abus.OUT1ADDRESS = 3'd5;
    tick();
    chk("overwrite", abus.OUT1, 8'hFF);
    abus.RESTORE = 1'b1;
    tick();
    abus.RESTORE = 1'b0;
    chk("restore_busy", {7'd0, abus.BUSY}, 8'h01);
    abus.OUT1ADDRESS = 3'd7;
    tick();
    chk("restore_read_live", abus.OUT1, 8'hFF);
    for (int k = 0; k < 7; k++) tick();
    chk("restore_done", {7'd0, abus.BUSY}, 8'h00);
    for (int i = 0; i < 8; i++) begin
      abus.OUT1ADDRESS = 3'(i);
      abus.OUT2ADDRESS = 3'(7 - i);
      tick();
      chk("restored_p1", abus.OUT1, 8'h10 + 8'(i));
      chk("restored_p2", abus.OUT2, 8'h17 - 8'(i));
    end

    // write dropped while busy; SAVE/RESTORE during busy not queued
    abus.SAVE = 1'b1;
    tick();
    abus.SAVE = 1'b0;
    wr(3'd2, 8'hAA);
    chk("drop_hi", {7'd0, abus.WRITE_DROP}, 8'h01);
    abus.RESTORE = 1'b1;
    tick();
    abus.RESTORE = 1'b0;
    chk("drop_lo", {7'd0, abus.WRITE_DROP}, 8'h00);
    for (int k = 0; k < 5; k++) tick();
    chk("busy_mid", {7'd0, abus.BUSY}, 8'h01);
    tick();
    chk("busy_end", {7'd0, abus.BUSY}, 8'h00);
    abus.OUT1ADDRESS = 3'd2;
    tick();
    chk("not_queued", {7'd0, abus.BUSY}, 8'h00);
    chk("r2_unchanged", abus.OUT1, 8'h12);

    // SAVE priority and write-before-save at the same edge
    abus.WRITE = 1'b1; abus.INADDRESS = 3'd4; abus.IN = 8'h44;
    abus.SAVE = 1'b1; abus.RESTORE = 1'b1;
    tick();
    abus.WRITE = 1'b0; abus.SAVE = 1'b0; abus.RESTORE = 1'b0;
    chk("both_busy", {7'd0, abus.BUSY}, 8'h01);
    for (int k = 0; k < 8; k++) tick();
    chk("both_done", {7'd0, abus.BUSY}, 8'h00);
    wr(3'd4, 8'h00);
    abus.RESTORE = 1'b1;
    tick();
    abus.RESTORE = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    abus.OUT1ADDRESS = 3'd4;
    tick();
    chk("saved_written", abus.OUT1, 8'h44);

    // reset aborts a copy in progress
    abus.SAVE = 1'b1; abus.RESTORE = 1'b1;
    tick();
    abus.SAVE = 1'b0; abus.RESTORE = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {7'd0, abus.BUSY}, 8'h00);
    chk("abort_out1", abus.OUT1, 8'h00);
    for (int i = 0; i < 8; i++) begin
      abus.OUT1ADDRESS = 3'(i);
      tick();
      chk("abort_main", abus.OUT1, 8'h00);
    end
    abus.RESTORE = 1'b1;
    tick();
    abus.RESTORE = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    abus.OUT1ADDRESS = 3'd4;
    tick();
    chk("abort_shadow", abus.OUT1, 8'h00);

    // ZERO_REG instance
    zbus.WRITE = 1'b1; zbus.INADDRESS = 3'd0; zbus.IN = 8'h33; zbus.OUT1ADDRESS = 3'd0;
    tick();
    zbus.WRITE = 1'b0;
    chk("z_bypass", zbus.OUT1, 8'h00);
    chk("z_nodrop", {7'd0, zbus.WRITE_DROP}, 8'h00);
    tick();
    chk("z_read0", zbus.OUT1, 8'h00);
    zbus.WRITE = 1'b1; zbus.INADDRESS = 3'd1; zbus.IN = 8'h77; zbus.OUT2ADDRESS = 3'd1;
    tick();
    zbus.WRITE = 1'b0;
    chk("z_r1", zbus.OUT2, 8'h77);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file_ctx.md
REG_FILE_CTX -- requirements
Module: reg_file_ctx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the register width.
REQ-002 Parameter ADDR_WIDTH, default 3, SHALL set the address width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 Parameter ZERO_REG, default 0, SHALL, when 1, make register 0 read as zero and ignore writes to it.
REQ-004 CLK  in  1  SHALL be the single clock; all state updates on its posedge.
REQ-005 RESET  in  1  SHALL be a synchronous, active-high reset, sampled on posedge CLK.
REQ-006 IN  in  DATA_WIDTH  SHALL carry the write data.
REQ-007 INADDRESS  in  ADDR_WIDTH  SHALL carry the write address.
REQ-008 WRITE  in  1  SHALL request a write of IN to INADDRESS.
REQ-009 OUT1ADDRESS, OUT2ADDRESS  in  ADDR_WIDTH  SHALL carry the read addresses of ports 1 and 2.
REQ-010 OUT1, OUT2  out  DATA_WIDTH  SHALL carry the registered read data of ports 1 and 2.
REQ-011 SAVE  in  1  SHALL request a copy of the main bank into the shadow bank.
REQ-012 RESTORE  in  1  SHALL request a copy of the shadow bank into the main bank.
REQ-013 BUSY  out  1  SHALL be high while a SAVE or RESTORE copy is in progress.
REQ-014 WRITE_DROP  out  1  SHALL pulse high for one cycle after a WRITE is rejected.

Function
REQ-015 Storage SHALL be a main bank and a shadow bank, each DEPTH x DATA_WIDTH.
REQ-016 Write acceptance: WRITE=1 and BUSY=0 at a posedge SHALL update main[INADDRESS] <= IN at that edge.
REQ-017 Reads SHALL have one-cycle latency: at each posedge, OUTn <= main[OUTnADDRESS] (pre-edge contents).
REQ-018 Read-during-write bypass: if a write is accepted at the same edge and INADDRESS == OUTnADDRESS, then OUTn SHALL take IN (write-first).
REQ-019 ZERO_REG=1: reads of address 0 SHALL return 0, including bypass; writes to address 0 SHALL be discarded without raising WRITE_DROP.
REQ-020 FSM states SHALL be IDLE, SAVING and RESTORING, with a copy counter cnt of width ADDR_WIDTH.
REQ-021 IDLE with SAVE=1 at a posedge SHALL go to SAVING with cnt=0; IDLE with RESTORE=1 and SAVE=0 SHALL go to RESTORING with cnt=0.
REQ-022 SAVE and RESTORE asserted together in IDLE SHALL start SAVING (SAVE priority).
REQ-023 SAVING: each posedge SHALL copy shadow[cnt] <= main[cnt] and increment cnt; at cnt = DEPTH-1 the FSM SHALL copy and return to IDLE.
REQ-024 RESTORING SHALL behave as in REQ-023 but copy main[cnt] <= shadow[cnt].
REQ-025 BUSY SHALL be registered: high for exactly DEPTH cycles, from the edge that accepts SAVE/RESTORE to the edge that completes the last copy.
REQ-026 SAVE/RESTORE asserted while BUSY=1 SHALL be ignored and not queued.
REQ-027 WRITE=1 while BUSY=1 SHALL be discarded; WRITE_DROP SHALL be high in the following cycle only.
REQ-028 A write accepted at the same edge as a SAVE/RESTORE acceptance SHALL complete first; SAVE SHALL copy the written value.
REQ-029 Reads during RESTORING SHALL return current main contents, with no bypass from the copy path.
REQ-030 The counter SHALL wrap DEPTH-1 -> 0 only on return to IDLE; it SHALL be 0 in IDLE.

Reset
REQ-031 RESET=1 at a posedge SHALL clear all main and shadow registers to 0.
REQ-032 RESET SHALL set OUT1=0, OUT2=0, BUSY=0, WRITE_DROP=0, state=IDLE and cnt=0.
REQ-033 RESET SHALL take priority over WRITE, SAVE and RESTORE at the same edge.
REQ-034 RESET asserted mid-copy SHALL abort the copy, leaving both banks zeroed.

Verification
REQ-035 Reset, then write 0x11 to reg 0 and 0x88 to reg 1; read addresses 0/1 -> OUT1=0x11 and OUT2=0x88 one cycle after addresses are applied.
REQ-036 Write 0x5A to reg 3 with OUT1ADDRESS=3 in the same cycle -> OUT1=0x5A after that edge (bypass).
REQ-037 Load regs 0..7 with 0x10..0x17, SAVE, wait 8 cycles (BUSY high exactly 8), overwrite all with 0xFF, RESTORE -> after 8 cycles reads return 0x10..0x17.
REQ-038 WRITE of 0xAA to reg 2 during BUSY -> WRITE_DROP high for 1 cycle and reg 2 unchanged.
REQ-039 SAVE and RESTORE asserted together in IDLE -> SAVING entered and shadow updated; RESET on the 4th busy cycle -> BUSY=0 and all reads return 0.
REQ-040 ZERO_REG=1: write 0x33 to reg 0 -> OUT1=0x00 for address 0 and WRITE_DROP=0.
